// File: rtl/av_ioctl_uploader_pkg.sv
// Shared constants and types for the Adventure Vision ioctl upload (readback) path.
package av_ioctl_pkg;

  localparam logic [5:0] IDX_CART0 = 6'd0;
  localparam logic [5:0] IDX_CART1 = 6'd1;
  localparam logic [5:0] IDX_PAL   = 6'd3;

  typedef enum logic [1:0] {IDLE, CART_ISSUE, CART_LAT, DONE} upload_state_t;

  typedef enum logic [1:0] {CART, PAL, NONE} target_t;

  function automatic target_t decode_target(input logic [5:0] index);
    case (index)
      IDX_CART0, IDX_CART1: return CART;
      IDX_PAL:              return PAL;
      default:              return NONE;
    endcase
  endfunction

endpackage

// File: rtl/av_ioctl_uploader_pal_byte_sel.sv
// Combinational 16:1 byte mux over the palette vector; byte 0 lives in the top bits.
module av_pal_byte_sel #(
  parameter int PAL_BYTES = 16
) (
  input  logic [8*PAL_BYTES-1:0] palette,
  input  logic [3:0]             sel,
  output logic [7:0]             pal_byte
);

  always_comb begin
    pal_byte = 8'h00;
    for (int i = 0; i < PAL_BYTES; i++) begin
      if (sel == 4'(i)) pal_byte = palette[8*(PAL_BYTES-1-i) +: 8];
    end
  end

endmodule

// File: rtl/av_ioctl_uploader.sv
// Serves HPS upload reads: cart RAM (index 0/1), palette register (index 3), 0xFF otherwise.
// Optional running checksum of delivered bytes when AV_UPLOAD_CKSUM_EN is defined.
module av_ioctl_uploader
  import av_ioctl_pkg::*;
#(
  parameter int ADDR_W    = 12,
  parameter int RD_LAT    = 1,
  parameter int PAL_BYTES = 16
) (
  input  logic                   clk_sys,
  input  logic                   reset,
  input  logic                   ioctl_upload,
  input  logic [7:0]             ioctl_index,
  input  logic                   ioctl_rd,
  input  logic [24:0]            ioctl_addr,
  output logic [7:0]             ioctl_din,
  output logic                   ioctl_wait,
  output logic [ADDR_W-1:0]      mem_addr,
  output logic                   mem_rd,
  input  logic [7:0]             mem_dout,
  input  logic [8*PAL_BYTES-1:0] palette,
  output logic                   busy
`ifdef AV_UPLOAD_CKSUM_EN
  ,
  output logic [7:0]             cksum,
  output logic [ADDR_W:0]        cksum_cnt
`endif
);

  localparam logic [1:0] LAT_LOAD = 2'(RD_LAT - 1);

  upload_state_t state;
  target_t       tgt;
  logic [1:0]    lat_cnt;
  logic [7:0]    pal_byte;
  logic          din_load;
  logic [7:0]    din_next;
  logic          unused_bits;

  assign tgt         = decode_target(ioctl_index[5:0]);
  assign busy        = (state != IDLE);
  assign unused_bits = &{1'b0, ioctl_index[7:6], ioctl_addr[24:ADDR_W]};

  av_pal_byte_sel #(.PAL_BYTES(PAL_BYTES)) u_pal_sel (
    .palette  (palette),
    .sel      (ioctl_addr[3:0]),
    .pal_byte (pal_byte)
  );

  // Single point where a byte is handed to hps_io; the checksum taps the same strobe.
  always_comb begin
    din_load = 1'b0;
    din_next = ioctl_din;
    case (state)
      IDLE: begin
        if (ioctl_rd && ioctl_upload) begin
          if (tgt == PAL) begin
            din_load = 1'b1;
            din_next = pal_byte;
          end else if (tgt == NONE) begin
            din_load = 1'b1;
            din_next = 8'hFF;
          end
        end
      end
      CART_LAT: begin
        if (lat_cnt == 2'd0) begin
          din_load = 1'b1;
          din_next = mem_dout;
        end
      end
      default: ;
    endcase
  end

  // CART_ISSUE covers the cycle mem_rd is on the bus, so the countdown spans RD_LAT cycles of RAM latency.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state      <= IDLE;
      lat_cnt    <= 2'd0;
      ioctl_din  <= 8'h00;
      ioctl_wait <= 1'b0;
      mem_rd     <= 1'b0;
      mem_addr   <= '0;
    end else begin
      mem_rd <= 1'b0;
      if (din_load) ioctl_din <= din_next;
      case (state)
        IDLE: begin
          if (ioctl_rd && ioctl_upload && tgt == CART) begin
            mem_addr   <= ioctl_addr[ADDR_W-1:0];
            mem_rd     <= 1'b1;
            ioctl_wait <= 1'b1;
            lat_cnt    <= LAT_LOAD;
            state      <= CART_ISSUE;
          end
        end
        CART_ISSUE: state <= CART_LAT;
        CART_LAT: begin
          if (lat_cnt == 2'd0) begin
            ioctl_wait <= 1'b0;
            state      <= DONE;
          end else begin
            lat_cnt <= lat_cnt - 2'd1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef AV_UPLOAD_CKSUM_EN
  logic upload_q;

  // A fresh upload session restarts the sum; the count sticks at all-ones.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      upload_q  <= 1'b0;
      cksum     <= 8'h00;
      cksum_cnt <= '0;
    end else begin
      upload_q <= ioctl_upload;
      if (ioctl_upload && !upload_q) begin
        cksum     <= 8'h00;
        cksum_cnt <= '0;
      end else if (din_load && ioctl_upload) begin
        cksum <= cksum + din_next;
        if (cksum_cnt != '1) cksum_cnt <= cksum_cnt + 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_av_ioctl_uploader.sv
// Self-checking bench: two uploaders (RD_LAT=1 and RD_LAT=3) driven in lockstep against a byte-level model.
module tb_av_ioctl_uploader;

  logic         clk_sys = 1'b0;
  logic         reset;
  logic         ioctl_upload;
  logic [7:0]   ioctl_index;
  logic         ioctl_rd;
  logic [24:0]  ioctl_addr;
  logic [127:0] palette;

  logic [7:0]  ioctl_din1, ioctl_din3, mem_dout1, mem_dout3;
  logic        ioctl_wait1, ioctl_wait3, mem_rd1, mem_rd3, busy1, busy3;
  logic [11:0] mem_addr1, mem_addr3;
`ifdef AV_UPLOAD_CKSUM_EN
  logic [7:0]  cksum1, cksum3;
  logic [12:0] cksum_cnt1, cksum_cnt3;
  int          exp_sum, exp_cnt;
`endif

  logic [7:0] cart_mem [0:4095];
  logic [7:0] pipe1;
  logic [7:0] pipe3 [0:2];

  int test_count = 0;
  int fail_count = 0;

  int         wait_cnt1, wait_cnt3, rd_cnt1, rd_cnt3;
  logic [7:0] first_din1, first_din3, drop_din1, drop_din3, prev_din1, prev_din3;
  logic       saw_drop1, saw_drop3;

  always #5 clk_sys = ~clk_sys;

  av_ioctl_uploader #(.ADDR_W(12), .RD_LAT(1), .PAL_BYTES(16)) u_dut1 (
    .clk_sys(clk_sys), .reset(reset), .ioctl_upload(ioctl_upload), .ioctl_index(ioctl_index),
    .ioctl_rd(ioctl_rd), .ioctl_addr(ioctl_addr), .ioctl_din(ioctl_din1), .ioctl_wait(ioctl_wait1),
    .mem_addr(mem_addr1), .mem_rd(mem_rd1), .mem_dout(mem_dout1), .palette(palette), .busy(busy1)
`ifdef AV_UPLOAD_CKSUM_EN
    , .cksum(cksum1), .cksum_cnt(cksum_cnt1)
`endif
  );

  av_ioctl_uploader #(.ADDR_W(12), .RD_LAT(3), .PAL_BYTES(16)) u_dut3 (
    .clk_sys(clk_sys), .reset(reset), .ioctl_upload(ioctl_upload), .ioctl_index(ioctl_index),
    .ioctl_rd(ioctl_rd), .ioctl_addr(ioctl_addr), .ioctl_din(ioctl_din3), .ioctl_wait(ioctl_wait3),
    .mem_addr(mem_addr3), .mem_rd(mem_rd3), .mem_dout(mem_dout3), .palette(palette), .busy(busy3)
`ifdef AV_UPLOAD_CKSUM_EN
    , .cksum(cksum3), .cksum_cnt(cksum_cnt3)
`endif
  );

  // Cart RAM models: data appears RD_LAT edges after the mem_rd strobe, garbage otherwise.
  always @(posedge clk_sys) begin
    pipe1    <= mem_rd1 ? cart_mem[mem_addr1] : 8'hEE;
    pipe3[0] <= mem_rd3 ? cart_mem[mem_addr3] : 8'hEE;
    pipe3[1] <= pipe3[0];
    pipe3[2] <= pipe3[1];
  end
  assign mem_dout1 = pipe1;
  assign mem_dout3 = pipe3[2];

  function automatic logic [7:0] ref_byte(input logic [7:0] idx, input logic [24:0] addr);
    int sel;
    sel = int'(idx[5:0]);
    if (sel == 0 || sel == 1) return cart_mem[addr % 4096];
    if (sel == 3) return palette[127 - 8*int'(addr[3:0]) -: 8];
    return 8'hFF;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    test_count++;
    assert (observed === expected)
    else begin
      fail_count++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // One rd strobe, then nine sampled cycles; optional stray strobe and upload drop mid-read.
  task automatic applyStimulus(input logic [7:0] idx, input logic [24:0] addr,
                               input int dup_cycle, input int drop_cycle);
    wait_cnt1 = 0; wait_cnt3 = 0; rd_cnt1 = 0; rd_cnt3 = 0;
    saw_drop1 = 1'b0; saw_drop3 = 1'b0;
    drop_din1 = 8'h00; drop_din3 = 8'h00;
    prev_din1 = ioctl_din1; prev_din3 = ioctl_din3;
    ioctl_index = idx;
    ioctl_addr  = addr;
    ioctl_rd    = 1'b1;
    @(posedge clk_sys); #1;
    ioctl_rd = 1'b0;
    for (int i = 0; i < 9; i++) begin
      if (i == 0) begin
        first_din1 = ioctl_din1;
        first_din3 = ioctl_din3;
      end
      if (ioctl_wait1) wait_cnt1++;
      else if (wait_cnt1 > 0 && !saw_drop1) begin saw_drop1 = 1'b1; drop_din1 = ioctl_din1; end
      if (ioctl_wait3) wait_cnt3++;
      else if (wait_cnt3 > 0 && !saw_drop3) begin saw_drop3 = 1'b1; drop_din3 = ioctl_din3; end
      if (mem_rd1) rd_cnt1++;
      if (mem_rd3) rd_cnt3++;
      if (i == dup_cycle) begin
        ioctl_addr = addr ^ 25'h0000155;
        ioctl_rd   = 1'b1;
      end
      if (i == drop_cycle) ioctl_upload = 1'b0;
      @(posedge clk_sys); #1;
      ioctl_rd = 1'b0;
    end
  endtask

  task automatic checkRead(input string tag, input logic [7:0] idx, input logic [24:0] addr, input bit active);
    logic [7:0] exp;
    bit         is_cart;
    is_cart = active && (idx[5:0] == 6'd0 || idx[5:0] == 6'd1);
    exp     = ref_byte(idx, addr);
    if (!active) begin
      checkOutput({tag, "/hold1"}, ioctl_din1, prev_din1);
      checkOutput({tag, "/hold3"}, ioctl_din3, prev_din3);
    end else begin
      checkOutput({tag, "/din1"}, ioctl_din1, exp);
      checkOutput({tag, "/din3"}, ioctl_din3, exp);
    end
    if (is_cart) begin
      checkOutput({tag, "/wait1"}, wait_cnt1, 2);
      checkOutput({tag, "/wait3"}, wait_cnt3, 4);
      checkOutput({tag, "/drop_din1"}, drop_din1, exp);
      checkOutput({tag, "/drop_din3"}, drop_din3, exp);
      checkOutput({tag, "/mem_rd1"}, rd_cnt1, 1);
      checkOutput({tag, "/mem_rd3"}, rd_cnt3, 1);
      checkOutput({tag, "/mem_addr1"}, mem_addr1, addr[11:0]);
      checkOutput({tag, "/mem_addr3"}, mem_addr3, addr[11:0]);
    end else begin
      if (active) begin
        checkOutput({tag, "/lat1"}, first_din1, exp);
        checkOutput({tag, "/lat3"}, first_din3, exp);
      end
      checkOutput({tag, "/wait1"}, wait_cnt1, 0);
      checkOutput({tag, "/wait3"}, wait_cnt3, 0);
      checkOutput({tag, "/mem_rd1"}, rd_cnt1, 0);
      checkOutput({tag, "/mem_rd3"}, rd_cnt3, 0);
    end
    checkOutput({tag, "/busy1"}, busy1, 1'b0);
    checkOutput({tag, "/busy3"}, busy3, 1'b0);
`ifdef AV_UPLOAD_CKSUM_EN
    if (active && ioctl_upload) begin
      exp_sum = (exp_sum + int'(exp)) % 256;
      exp_cnt = exp_cnt + 1;
    end
    checkOutput({tag, "/cksum1"}, cksum1, exp_sum);
    checkOutput({tag, "/cksum3"}, cksum3, exp_sum);
    checkOutput({tag, "/cnt1"}, cksum_cnt1, exp_cnt);
    checkOutput({tag, "/cnt3"}, cksum_cnt3, exp_cnt);
`endif
  endtask

  task automatic setUpload(input logic v);
`ifdef AV_UPLOAD_CKSUM_EN
    if (v && !ioctl_upload) begin
      exp_sum = 0;
      exp_cnt = 0;
    end
`endif
    ioctl_upload = v;
    @(posedge clk_sys); #1;
  endtask

  initial begin
    logic [7:0]  r_idx;
    logic [24:0] r_addr;
    for (int i = 0; i < 4096; i++) cart_mem[i] = 8'($urandom);
    cart_mem[12'h123] = 8'hA5;
    cart_mem[12'h005] = 8'h3C;
    cart_mem[12'h200] = 8'h02;
    cart_mem[12'h201] = 8'h10;
    palette      = 128'h828214517356305A5F1A3B4900000000;
    reset        = 1'b1;
    ioctl_upload = 1'b1;
    ioctl_index  = 8'h00;
    ioctl_rd     = 1'b1;
    ioctl_addr   = 25'h123;
`ifdef AV_UPLOAD_CKSUM_EN
    exp_sum = 0;
    exp_cnt = 0;
`endif
    repeat (3) @(posedge clk_sys);
    #1;
    checkOutput("reset/din1", ioctl_din1, 8'h00);
    checkOutput("reset/din3", ioctl_din3, 8'h00);
    checkOutput("reset/wait1", ioctl_wait1, 1'b0);
    checkOutput("reset/mem_rd3", mem_rd3, 1'b0);
    checkOutput("reset/mem_addr1", mem_addr1, 12'h000);
    checkOutput("reset/busy3", busy3, 1'b0);
    ioctl_rd = 1'b0;
    reset    = 1'b0;
    @(posedge clk_sys); #1;

    applyStimulus(8'h00, 25'h123, -1, -1);
    checkRead("cart_a5", 8'h00, 25'h123, 1'b1);

    applyStimulus(8'h03, 25'd0, -1, -1);  checkRead("pal0", 8'h03, 25'd0, 1'b1);
    applyStimulus(8'h03, 25'd1, -1, -1);  checkRead("pal1", 8'h03, 25'd1, 1'b1);
    applyStimulus(8'h03, 25'd15, -1, -1); checkRead("pal15", 8'h03, 25'd15, 1'b1);
    checkOutput("pal15/value", ioctl_din1, 8'h00);
    applyStimulus(8'h03, 25'd16, -1, -1); checkRead("pal16", 8'h03, 25'd16, 1'b1);
    checkOutput("pal16/value", ioctl_din1, 8'h82);

    applyStimulus(8'h05, 25'h0ABCDE, -1, -1);
    checkRead("none", 8'h05, 25'h0ABCDE, 1'b1);

    applyStimulus(8'h01, 25'h1005, 1, -1);
    checkRead("wrap_dup", 8'h01, 25'h1005, 1'b1);
    checkOutput("wrap_dup/value", ioctl_din3, 8'h3C);

    applyStimulus(8'hC3, 25'd2, -1, -1);
    checkRead("idx_hi_bits", 8'hC3, 25'd2, 1'b1);

    setUpload(1'b0);
    applyStimulus(8'h00, 25'h123, -1, -1);
    checkRead("no_upload_cart", 8'h00, 25'h123, 1'b0);
    applyStimulus(8'h03, 25'd4, -1, -1);
    checkRead("no_upload_pal", 8'h03, 25'd4, 1'b0);
    setUpload(1'b1);

    applyStimulus(8'h00, 25'h1FF_F777, -1, 0);
    checkRead("upload_drop", 8'h00, 25'h1FF_F777, 1'b1);
    setUpload(1'b1);

    // Reset lands while both instances are counting down a cart read.
    ioctl_index = 8'h00;
    ioctl_addr  = 25'h321;
    ioctl_rd    = 1'b1;
    @(posedge clk_sys); #1;
    ioctl_rd = 1'b0;
    @(posedge clk_sys); #1;
    reset = 1'b1;
    @(posedge clk_sys); #1;
    reset = 1'b0;
    checkOutput("rst_mid/wait1", ioctl_wait1, 1'b0);
    checkOutput("rst_mid/wait3", ioctl_wait3, 1'b0);
    checkOutput("rst_mid/din1", ioctl_din1, 8'h00);
    checkOutput("rst_mid/din3", ioctl_din3, 8'h00);
    checkOutput("rst_mid/busy1", busy1, 1'b0);
    checkOutput("rst_mid/busy3", busy3, 1'b0);
`ifdef AV_UPLOAD_CKSUM_EN
    exp_sum = 0;
    exp_cnt = 0;
`endif
    @(posedge clk_sys); #1;
    applyStimulus(8'h00, 25'h321, -1, -1);
    checkRead("after_rst", 8'h00, 25'h321, 1'b1);

`ifdef AV_UPLOAD_CKSUM_EN
    setUpload(1'b0);
    setUpload(1'b1);
    @(posedge clk_sys); #1;
    checkOutput("ck_clear/sum", cksum1, 8'h00);
    checkOutput("ck_clear/cnt", cksum_cnt3, 13'd0);
    applyStimulus(8'h05, 25'd7, -1, -1);     checkRead("ck_ff", 8'h05, 25'd7, 1'b1);
    applyStimulus(8'h00, 25'h200, -1, -1);   checkRead("ck_02", 8'h00, 25'h200, 1'b1);
    applyStimulus(8'h01, 25'h1201, -1, -1);  checkRead("ck_10", 8'h01, 25'h1201, 1'b1);
    checkOutput("ck_total/sum", cksum1, 8'h11);
    checkOutput("ck_total/cnt", cksum_cnt1, 13'd3);
    setUpload(1'b0);
    setUpload(1'b1);
    @(posedge clk_sys); #1;
    checkOutput("ck_reraise/sum", cksum3, 8'h00);
    checkOutput("ck_reraise/cnt", cksum_cnt1, 13'd0);
`endif

    for (int n = 0; n < 24; n++) begin
      if (n % 8 == 0) palette = {$urandom, $urandom, $urandom, $urandom};
      case ($urandom_range(0, 4))
        0:       r_idx = 8'h00;
        1:       r_idx = 8'h01;
        2:       r_idx = 8'h03;
        3:       r_idx = 8'h05;
        default: r_idx = 8'($urandom);
      endcase
      r_addr = 25'($urandom);
      applyStimulus(r_idx, r_addr, ($urandom_range(0, 3) == 0) ? 1 : -1, -1);
      checkRead($sformatf("rand%0d_idx%0h", n, r_idx), r_idx, r_addr, 1'b1);
    end

    $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
    $finish;
  end

endmodule
